// File: rtl/huffman_ac_decoder_if.sv
// Bit-stream input and decoded-symbol output of the JPEG AC Huffman decoder.
interface huffman_ac_decoder_if;
   logic        bit_in;
   logic        bit_valid;
   logic        bit_ready;
   logic        sym_valid;
   logic        sym_ready;
   logic [3:0]  run_out;
   logic [3:0]  size_out;
   logic [10:0] coeff_out;
   logic        eob_out;
   logic        block_done;

   modport master (
      output bit_in, bit_valid, sym_ready,
      input  bit_ready, sym_valid, run_out, size_out, coeff_out, eob_out, block_done
   );
   modport slave (
      input  bit_in, bit_valid, sym_ready,
      output bit_ready, sym_valid, run_out, size_out, coeff_out, eob_out, block_done
   );
endinterface

// File: rtl/huffman_ac_decoder.sv
// Bit-serial canonical Huffman decoder for JPEG AC coefficients with a host-loaded
// DHT-style table (BITS counts + HUFFVAL list).
module huffman_ac_decoder #(
   parameter int MAX_LEN  = 16,
   parameter int NUM_SYMS = 162
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 tbl_we,
   input  logic                 tbl_sel,
   input  logic [7:0]           tbl_addr,
   input  logic [7:0]           tbl_data,
   input  logic                 start,
   output logic                 err,
   huffman_ac_decoder_if.slave  stream
);
   typedef enum logic [2:0] {IDLE, CODE, AMP, OUT, ERR} state_t;

   typedef struct packed {
      logic [3:0]  run;
      logic [3:0]  size;
      logic [10:0] coeff;
      logic        eob;
   } sym_t;

   state_t      state_q, state_d;
   logic [16:0] code_q, code_d, first_q, first_d;
   logic [4:0]  len_q, len_d;
   logic [7:0]  index_q, index_d;
   logic [6:0]  k_q, k_d;
   logic [9:0]  amp_q, amp_d;
   logic [3:0]  acnt_q, acnt_d;
   sym_t        sym_q, sym_d;
   logic        done_q, done_d;

   logic [7:0]  bits_mem [16];
   logic [7:0]  huffval  [NUM_SYMS];

   logic        take, hit, idx_ok;
   logic [16:0] code_s, diff;
   logic [7:0]  cnt, sym;
   logic [8:0]  sym_idx;
   logic [9:0]  amp_s;
   logic [10:0] amp_x, top, mask, coeff_v;
   logic [7:0]  k_coef, k_zrl;

   // Canonical step: a code of the current length matches when it falls within
   // the cnt codes starting at 'first'.
   assign take    = stream.bit_valid && (state_q == CODE || state_q == AMP);
   assign code_s  = (code_q << 1) | {16'd0, stream.bit_in};
   assign cnt     = bits_mem[len_q[3:0]];
   assign diff    = code_s - first_q;
   assign hit     = diff < {9'd0, cnt};
   assign sym_idx = {1'b0, index_q} + diff[8:0];
   assign idx_ok  = {23'd0, sym_idx} < NUM_SYMS;
   assign sym     = idx_ok ? huffval[sym_idx[7:0]] : 8'h00;

   // Amplitude: a leading 0 marks a negative value stored as v + 2^S - 1.
   assign amp_s   = (amp_q << 1) | {9'd0, stream.bit_in};
   assign amp_x   = {1'b0, amp_s};
   assign top     = 11'd1 << (sym_q.size - 4'd1);
   assign mask    = (top << 1) - 11'd1;
   assign coeff_v = |(amp_x & top) ? amp_x : amp_x - mask;
   assign k_coef  = {1'b0, k_q} + {4'd0, sym_q.run} + 8'd1;
   assign k_zrl   = {1'b0, k_q} + 8'd16;

   assign stream.bit_ready  = (state_q == CODE) || (state_q == AMP);
   assign stream.sym_valid  = (state_q == OUT);
   assign stream.run_out    = sym_q.run;
   assign stream.size_out   = sym_q.size;
   assign stream.coeff_out  = sym_q.coeff;
   assign stream.eob_out    = sym_q.eob;
   assign stream.block_done = done_q;
   assign err               = (state_q == ERR);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         bits_mem <= '{default: '0};
         huffval  <= '{default: '0};
      end else if (tbl_we && state_q == IDLE) begin
         if (!tbl_sel)
            bits_mem[tbl_addr[3:0]] <= tbl_data;
         else if ({24'd0, tbl_addr} < NUM_SYMS)
            huffval[tbl_addr] <= tbl_data;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         code_q  <= '0;
         first_q <= '0;
         len_q   <= '0;
         index_q <= '0;
         k_q     <= '0;
         amp_q   <= '0;
         acnt_q  <= '0;
         sym_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         first_q <= first_d;
         len_q   <= len_d;
         index_q <= index_d;
         k_q     <= k_d;
         amp_q   <= amp_d;
         acnt_q  <= acnt_d;
         sym_q   <= sym_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      first_d = first_q;
      len_d   = len_q;
      index_d = index_q;
      k_d     = k_q;
      amp_d   = amp_q;
      acnt_d  = acnt_q;
      sym_d   = sym_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE, ERR: begin
            if (start) begin
               state_d = CODE;
               code_d  = '0;
               first_d = '0;
               len_d   = '0;
               index_d = '0;
               k_d     = '0;
            end
         end
         CODE: begin
            if (take) begin
               if (hit) begin
                  code_d     = '0;
                  first_d    = '0;
                  len_d      = '0;
                  index_d    = '0;
                  amp_d      = '0;
                  acnt_d     = '0;
                  sym_d.run  = sym[7:4];
                  sym_d.size = sym[3:0];
                  sym_d.coeff = '0;
                  sym_d.eob  = 1'b0;
                  if (!idx_ok)
                     state_d = ERR;
                  else if (sym[3:0] != 4'd0)
                     state_d = (sym[3:0] > 4'd10) ? ERR : AMP;
                  else if (sym[7:4] == 4'd0) begin
                     sym_d.eob = 1'b1;
                     state_d   = OUT;
                  end else if (sym[7:4] == 4'hF && k_zrl <= 8'd63) begin
                     k_d     = k_zrl[6:0];
                     state_d = OUT;
                  end else
                     state_d = ERR;
               end else if (len_q == 5'(MAX_LEN - 1)) begin
                  state_d = ERR;
               end else begin
                  code_d  = code_s;
                  index_d = index_q + cnt;
                  first_d = (first_q + {9'd0, cnt}) << 1;
                  len_d   = len_q + 5'd1;
               end
            end
         end
         AMP: begin
            if (take) begin
               amp_d  = amp_s;
               acnt_d = acnt_q + 4'd1;
               if (acnt_q + 4'd1 == sym_q.size) begin
                  sym_d.coeff = coeff_v;
                  if (k_coef > 8'd63)
                     state_d = ERR;
                  else begin
                     k_d     = k_coef[6:0];
                     state_d = OUT;
                  end
               end
            end
         end
         OUT: begin
            if (stream.sym_ready) begin
               if (sym_q.eob || k_q == 7'd63) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else
                  state_d = CODE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_huffman_ac_decoder.sv
// Self-checking bench: an encoder-side model builds canonical codes from the DHT
// table and produces both the bitstream and the expected decoded symbols.
module tb_huffman_ac_decoder;
   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       tbl_we = 1'b0, tbl_sel = 1'b0, start = 1'b0;
   logic [7:0] tbl_addr = '0, tbl_data = '0;
   logic       err;

   huffman_ac_decoder_if sif ();

   huffman_ac_decoder #(.MAX_LEN(16), .NUM_SYMS(162)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .tbl_we(tbl_we), .tbl_sel(tbl_sel),
      .tbl_addr(tbl_addr), .tbl_data(tbl_data), .start(start), .err(err), .stream(sif)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [3:0]  run;
      logic [3:0]  size;
      logic [10:0] coeff;
      logic        eob;
      bit          last;
   } exp_t;

   int vectors = 0, miscompares = 0;
   bit seen_sv;
   bit   bitq [$];
   exp_t expq [$];
   int   hcode [256];
   int   hlen  [256];

   int lum_bits [16] = '{0, 2, 1, 3, 3, 2, 4, 3, 5, 5, 4, 4, 0, 0, 1, 125};
   int lum_val [162] = '{
      'h01,'h02,'h03,'h00,'h04,'h11,'h05,'h12,'h21,'h31,'h41,'h06,'h13,'h51,'h61,'h07,
      'h22,'h71,'h14,'h32,'h81,'h91,'ha1,'h08,'h23,'h42,'hb1,'hc1,'h15,'h52,'hd1,'hf0,
      'h24,'h33,'h62,'h72,'h82,'h09,'h0a,'h16,'h17,'h18,'h19,'h1a,'h25,'h26,'h27,'h28,
      'h29,'h2a,'h34,'h35,'h36,'h37,'h38,'h39,'h3a,'h43,'h44,'h45,'h46,'h47,'h48,'h49,
      'h4a,'h53,'h54,'h55,'h56,'h57,'h58,'h59,'h5a,'h63,'h64,'h65,'h66,'h67,'h68,'h69,
      'h6a,'h73,'h74,'h75,'h76,'h77,'h78,'h79,'h7a,'h83,'h84,'h85,'h86,'h87,'h88,'h89,
      'h8a,'h92,'h93,'h94,'h95,'h96,'h97,'h98,'h99,'h9a,'ha2,'ha3,'ha4,'ha5,'ha6,'ha7,
      'ha8,'ha9,'haa,'hb2,'hb3,'hb4,'hb5,'hb6,'hb7,'hb8,'hb9,'hba,'hc2,'hc3,'hc4,'hc5,
      'hc6,'hc7,'hc8,'hc9,'hca,'hd2,'hd3,'hd4,'hd5,'hd6,'hd7,'hd8,'hd9,'hda,'he1,'he2,
      'he3,'he4,'he5,'he6,'he7,'he8,'he9,'hea,'hf1,'hf2,'hf3,'hf4,'hf5,'hf6,'hf7,'hf8,
      'hf9,'hfa};

   // ---------------- reference model (encoder side) ----------------
   task automatic build_codes();
      int code = 0, idx = 0;
      for (int l = 1; l <= 16; l++) begin
         for (int j = 0; j < lum_bits[l-1]; j++) begin
            hcode[lum_val[idx]] = code;
            hlen[lum_val[idx]]  = l;
            idx++;
            code++;
         end
         code = code << 1;
      end
   endtask

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) bitq.push_back(s[i] == "1");
   endtask

   task automatic push_exp(input int r, input int s, input int v, input bit eob, input bit last);
      exp_t e;
      e.run = 4'(r); e.size = 4'(s); e.coeff = 11'(v); e.eob = eob; e.last = last;
      expq.push_back(e);
   endtask

   task automatic push_code(input int sym);
      for (int b = hlen[sym] - 1; b >= 0; b--) bitq.push_back(hcode[sym][b]);
   endtask

   task automatic push_coef(input int r, input int v, input bit last);
      int mag, s, amp;
      mag = (v < 0) ? -v : v;
      s = 0;
      while ((1 << s) <= mag) s++;
      push_code(r * 16 + s);
      amp = (v > 0) ? v : v + (1 << s) - 1;
      for (int b = s - 1; b >= 0; b--) bitq.push_back(amp[b]);
      push_exp(r, s, v, 1'b0, last);
   endtask

   task automatic gen_block();
      int k, act, maxr, r, s, mag, v;
      bit fin;
      k = 0; fin = 0;
      while (!fin) begin
         act = $urandom_range(0, 9);
         if (k > 0 && act == 0) begin
            push_code(8'h00); push_exp(0, 0, 0, 1'b1, 1'b1); fin = 1;
         end else if (act == 1 && k + 16 < 63) begin
            push_code(8'hF0); push_exp(15, 0, 0, 1'b0, 1'b0); k += 16;
         end else begin
            maxr = (62 - k < 15) ? 62 - k : 15;
            r    = $urandom_range(0, maxr);
            s    = $urandom_range(1, 10);
            mag  = $urandom_range(1 << (s - 1), (1 << s) - 1);
            v    = $urandom_range(0, 1) ? -mag : mag;
            k   += r + 1;
            push_coef(r, v, k == 63);
            if (k == 63) fin = 1;
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic wr(input bit sel, input int addr, input int data, input bit st);
      @(negedge clk_in);
      tbl_we = 1'b1; tbl_sel = sel; tbl_addr = 8'(addr); tbl_data = 8'(data); start = st;
   endtask

   task automatic pulse_start();
      @(negedge clk_in); start = 1'b1;
      @(negedge clk_in); start = 1'b0;
   endtask

   task automatic drive_bits(input logic [15:0] pat, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_in);
         seen_sv |= (sif.sym_valid === 1'b1);
         sif.bit_valid = 1'b1; sif.bit_in = pat[15 - i];
      end
      @(negedge clk_in);
      sif.bit_valid = 1'b0;
   endtask

   // Streams bitq into the DUT and checks every accepted symbol against expq.
   task automatic run_stream(input int budget, input bit rnd);
      int cyc = 0;
      bit want_done = 0;
      exp_t e;
      while ((bitq.size() != 0 || expq.size() != 0 || want_done) && cyc < budget) begin
         @(negedge clk_in);
         cyc++;
         if (want_done) begin
            vectors++;
            if (sif.block_done !== 1'b1) begin
               miscompares++;
               $display("FAIL block_done got %b want 1", sif.block_done);
            end
            want_done = 0;
         end
         sif.sym_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (sif.sym_valid === 1'b1 && sif.sym_ready) begin
            vectors++;
            if (expq.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_sym got run=%0d size=%0d", sif.run_out, sif.size_out);
            end else begin
               e = expq.pop_front();
               if ({sif.run_out, sif.size_out, sif.coeff_out, sif.eob_out} !== {e.run, e.size, e.coeff, e.eob}) begin
                  miscompares++;
                  $display("FAIL sym got run=%0d size=%0d coeff=%0d eob=%b want run=%0d size=%0d coeff=%0d eob=%b",
                           sif.run_out, sif.size_out, $signed(sif.coeff_out), sif.eob_out,
                           e.run, e.size, $signed(e.coeff), e.eob);
               end
               want_done = e.last;
            end
         end
         tbl_we = 1'b0;
         if (rnd && sif.bit_ready === 1'b1 && $urandom_range(0, 7) == 0) begin
            tbl_we = 1'b1; tbl_sel = 1'($urandom); tbl_addr = 8'($urandom); tbl_data = 8'($urandom);
         end
         if (bitq.size() != 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
            sif.bit_valid = 1'b1; sif.bit_in = bitq[0];
            if (sif.bit_ready === 1'b1) void'(bitq.pop_front());
         end else begin
            sif.bit_valid = 1'b0; sif.bit_in = 1'($urandom);
         end
      end
      @(negedge clk_in);
      sif.bit_valid = 1'b0; sif.sym_ready = 1'b0; tbl_we = 1'b0;
      if (cyc >= budget) begin
         vectors++; miscompares++;
         $display("FAIL stream_timeout bits_left=%0d syms_left=%0d", bitq.size(), expq.size());
         bitq.delete(); expq.delete();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #23;
      vectors++;
      if ({sif.bit_ready, sif.sym_valid, sif.run_out, sif.size_out, sif.coeff_out, sif.eob_out, sif.block_done, err} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got rdy=%b sv=%b done=%b err=%b want all 0", sif.bit_ready, sif.sym_valid, sif.block_done, err);
      end
      @(negedge clk_in); rst_in = 1'b0;
      sif.bit_valid = 1'b1; sif.bit_in = 1'b1;
      repeat (3) @(negedge clk_in);
      sif.bit_valid = 1'b0;
      vectors++;
      if ({sif.bit_ready, sif.sym_valid, sif.block_done, err} !== 4'b0) begin
         miscompares++;
         $display("FAIL idle_outputs got rdy=%b sv=%b done=%b err=%b want 0", sif.bit_ready, sif.sym_valid, sif.block_done, err);
      end
   endtask

   task automatic test_table_load_first_symbol();
      for (int i = 0; i < 16; i++) wr(1'b0, i, lum_bits[i], 1'b0);
      wr(1'b1, 200, 'h55, 1'b0);
      for (int i = 0; i < 162; i++) wr(1'b1, i, lum_val[i], i == 161);
      @(negedge clk_in); tbl_we = 1'b0; start = 1'b0;
      vectors++;
      if (sif.bit_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL start_with_write bit_ready got %b want 1", sif.bit_ready);
      end
      push_str("001");  push_exp(0, 1, 1, 1'b0, 1'b0);
      push_str("0101"); push_exp(0, 2, -2, 1'b0, 1'b0);
      run_stream(200, 1'b0);
   endtask

   task automatic test_eob_zrl();
      push_str("11111111001"); push_exp(15, 0, 0, 1'b0, 1'b0);
      push_str("1010");        push_exp(0, 0, 0, 1'b1, 1'b1);
      run_stream(200, 1'b0);
      vectors++;
      if (sif.bit_ready !== 1'b0 || sif.sym_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL eob_idle got rdy=%b sv=%b want 0 0", sif.bit_ready, sif.sym_valid);
      end
   endtask

   task automatic test_full_block();
      pulse_start();
      for (int i = 0; i < 63; i++) begin
         push_str("000"); push_exp(0, 1, -1, 1'b0, i == 62);
      end
      run_stream(2000, 1'b0);
      vectors++;
      if (sif.bit_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full_block_ready got %b want 0", sif.bit_ready);
      end
   endtask

   task automatic test_invalid_code();
      pulse_start();
      seen_sv = 0;
      drive_bits(16'hFFFF, 15);
      vectors++;
      if (err !== 1'b0 || sif.bit_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL invalid_15bits got err=%b rdy=%b want 0 1", err, sif.bit_ready);
      end
      drive_bits(16'hFFFF, 1);
      vectors++;
      if (err !== 1'b1 || sif.bit_ready !== 1'b0 || seen_sv || sif.sym_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL invalid_16bits got err=%b rdy=%b sv_seen=%b want 1 0 0", err, sif.bit_ready, seen_sv);
      end
      pulse_start();
      vectors++;
      if (err !== 1'b0 || sif.bit_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL err_clear got err=%b rdy=%b want 0 1", err, sif.bit_ready);
      end
      push_str("1010"); push_exp(0, 0, 0, 1'b1, 1'b1);
      run_stream(200, 1'b0);
   endtask

   task automatic test_backpressure();
      pulse_start();
      sif.sym_ready = 1'b0;
      drive_bits(16'b0010_0000_0000_0000, 3);
      vectors++;
      if (sif.sym_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL latency sym_valid got %b want 1", sif.sym_valid);
      end
      sif.bit_valid = 1'b1; sif.bit_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_in);
         vectors++;
         if ({sif.sym_valid, sif.bit_ready, sif.run_out, sif.size_out, sif.coeff_out, sif.eob_out} !== {1'b1, 1'b0, 4'd0, 4'd1, 11'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL backpressure[%0d] got sv=%b rdy=%b run=%0d size=%0d coeff=%0d want 1 0 0 1 1",
                     i, sif.sym_valid, sif.bit_ready, sif.run_out, sif.size_out, $signed(sif.coeff_out));
         end
      end
      sif.sym_ready = 1'b1;
      @(negedge clk_in);
      sif.sym_ready = 1'b0; sif.bit_valid = 1'b0;
      push_str("1010"); push_exp(0, 0, 0, 1'b1, 1'b1);
      run_stream(200, 1'b0);
   endtask

   task automatic test_random_blocks();
      for (int b = 0; b < 12; b++) begin
         pulse_start();
         gen_block();
         run_stream(20000, 1'b1);
      end
   endtask

   task automatic test_reset_mid_amp();
      logic [15:0] pat;
      pulse_start();
      push_str("011");
      run_stream(100, 1'b0);
      vectors++;
      if (sif.bit_ready !== 1'b1 || sif.sym_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_amp got rdy=%b sv=%b want 1 0", sif.bit_ready, sif.sym_valid);
      end
      #2 rst_in = 1'b1;
      #1;
      vectors++;
      if ({sif.bit_ready, sif.sym_valid, sif.run_out, sif.size_out, sif.coeff_out, sif.eob_out, sif.block_done, err} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_amp got rdy=%b sv=%b size=%0d err=%b want all 0", sif.bit_ready, sif.sym_valid, sif.size_out, err);
      end
      @(negedge clk_in); rst_in = 1'b0;
      pulse_start();
      pat = 16'($urandom);
      seen_sv = 0;
      drive_bits(pat, 15);
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL cleared_table_15bits err got %b want 0", err);
      end
      drive_bits(pat << 15, 1);
      vectors++;
      if (err !== 1'b1 || seen_sv || sif.bit_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL cleared_table_16bits got err=%b sv_seen=%b rdy=%b want 1 0 0", err, seen_sv, sif.bit_ready);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      sif.bit_in = 1'b0; sif.bit_valid = 1'b0; sif.sym_ready = 1'b0;
      build_codes();
      test_reset();
      test_table_load_first_symbol();
      test_eob_zrl();
      test_full_block();
      test_invalid_code();
      test_backpressure();
      test_random_blocks();
      test_reset_mid_amp();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
